// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
// Frame-state encoding, parity polarity and legal data-width range shared by TX and RX.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP1  = 3'd5,
    STOP2  = 3'd6
  } tx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DW_MIN = 5;
  localparam int DW_MAX = 16;

  // Narrow words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [DW_MAX-1:0] word, input logic odd);
    return (^word) ^ (odd == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_frame_engine_if.sv
// rtl/uart_tx_frame_engine_if.sv - word handshake and per-frame config bundle
// The host side drives word plus frame options; the engine returns s_ready.
interface uart_tx_frame_engine_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  par_en;
  logic                  par_odd;
  logic                  stop2;
  logic                  msb_first;

  modport master (
    output s_valid, s_data, par_en, par_odd, stop2, msb_first,
    input  s_ready
  );

  modport slave (
    input  s_valid, s_data, par_en, par_odd, stop2, msb_first,
    output s_ready
  );

endinterface

// File: rtl/uart_tx_shifter.sv
// rtl/uart_tx_shifter.sv - data-bit shift register with direction select and bit index
// Presents the current and following data bit so the framer can register tx on the same tick.
module uart_tx_shifter
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic                  msb_first_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  head_o,
  output logic                  next_o,
  output logic                  last_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]      idx_q, idx_d;
  logic                  msb_q, msb_d;

  always_comb begin
    sr_d  = sr_q;
    idx_d = idx_q;
    msb_d = msb_q;
    if (load_i) begin
      sr_d  = data_i;
      idx_d = '0;
      msb_d = msb_first_i;
    end else if (shift_i) begin
      sr_d  = msb_q ? {sr_q[DATA_WIDTH-2:0], 1'b0} : {1'b0, sr_q[DATA_WIDTH-1:1]};
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q  <= '0;
      idx_q <= '0;
      msb_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      idx_q <= idx_d;
      msb_q <= msb_d;
    end
  end

  assign head_o = msb_q ? sr_q[DATA_WIDTH-1] : sr_q[0];
  assign next_o = msb_q ? sr_q[DATA_WIDTH-2] : sr_q[1];
  assign last_o = (idx_q == LAST_IDX);

endmodule

// File: rtl/uart_tx_frame_engine.sv
// rtl/uart_tx_frame_engine.sv - UART transmit framer (start, data, optional parity, 1/2 stop)
// Bits advance only on tick; all frame options are frozen when the word is accepted.
module uart_tx_frame_engine
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    tick_i,
  uart_tx_frame_engine_if.slave   s,
  output logic                    tx_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_ARMED  = ARMED;
  localparam logic [2:0] ST_START  = START;
  localparam logic [2:0] ST_DATA   = DATA;
  localparam logic [2:0] ST_PARITY = PARITY;
  localparam logic [2:0] ST_STOP1  = STOP1;
  localparam logic [2:0] ST_STOP2  = STOP2;

  if (DATA_WIDTH < DW_MIN || DATA_WIDTH > DW_MAX) begin : g_width_check
    $error("uart_tx_frame_engine: DATA_WIDTH out of range");
  end

  logic [2:0] state_q, state_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       par_en_q, par_en_d;
  logic       stop2_q, stop2_d;
  logic       par_bit_q, par_bit_d;

  logic accept;
  logic shift;
  logic head_bit, next_bit, last_bit;

  assign s.s_ready = (state_q == ST_IDLE);
  assign accept    = (state_q == ST_IDLE) && s.s_valid;

  uart_tx_shifter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shifter (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (accept),
    .shift_i     (shift),
    .msb_first_i (s.msb_first),
    .data_i      (s.s_data),
    .head_o      (head_bit),
    .next_o      (next_bit),
    .last_o      (last_bit)
  );

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    par_en_d  = par_en_q;
    stop2_d   = stop2_q;
    par_bit_d = par_bit_q;
    shift     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          state_d   = ST_ARMED;
          par_en_d  = s.par_en;
          stop2_d   = s.stop2;
          par_bit_d = parity_bit(DW_MAX'(s.s_data), s.par_odd);
        end
      end
      ST_ARMED: if (tick_i) begin
        state_d = ST_START;
        tx_d    = 1'b0;
      end
      ST_START: if (tick_i) begin
        state_d = ST_DATA;
        tx_d    = head_bit;
      end
      // tx is registered, so each tick loads the bit that the coming period carries.
      ST_DATA: if (tick_i) begin
        if (!last_bit) begin
          shift = 1'b1;
          tx_d  = next_bit;
        end else if (par_en_q) begin
          state_d = ST_PARITY;
          tx_d    = par_bit_q;
        end else begin
          state_d = ST_STOP1;
          tx_d    = 1'b1;
        end
      end
      ST_PARITY: if (tick_i) begin
        state_d = ST_STOP1;
        tx_d    = 1'b1;
      end
      ST_STOP1: if (tick_i) begin
        tx_d = 1'b1;
        if (stop2_q) begin
          state_d = ST_STOP2;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_STOP2: if (tick_i) begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      par_en_q  <= par_en_d;
      stop2_q   <= stop2_d;
      par_bit_q <= par_bit_d;
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule
